// File: rtl/rv32i_register_file.sv
// RV32I integer register file: 31 x 32-bit registers (x0 reads zero), two async read ports, one write port.
// Latency: write lands on the rising edge, reads are combinational; no backpressure, every write is accepted.
// Optional write-through forwarding to both read ports when REGFILE_BYPASS_EN is defined.
module rv32i_register_file (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] reg_write,
    input  logic        write,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic [31:0] reg1,
    output logic [31:0] reg2
);

    // x0 has no storage; the array starts at index 1.
    logic [31:0] regs [1:31];
    logic        wr_en;

    assign wr_en = write && (rd != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (wr_en) begin
            regs[rd] <= reg_write;
        end
    end

    logic [31:0] arr1;
    logic [31:0] arr2;

    always_comb begin
        arr1 = 32'd0;
        arr2 = 32'd0;
        if (rs1 != 5'd0) arr1 = regs[rs1];
        if (rs2 != 5'd0) arr2 = regs[rs2];
    end

`ifdef REGFILE_BYPASS_EN
    // A write in flight wins over the stale array contents, except while reset is clearing.
    logic fwd1;
    logic fwd2;

    assign fwd1 = wr_en && !rst && (rd == rs1);
    assign fwd2 = wr_en && !rst && (rd == rs2);

    assign reg1 = fwd1 ? reg_write : arr1;
    assign reg2 = fwd2 ? reg_write : arr2;
`else
    assign reg1 = arr1;
    assign reg2 = arr2;
`endif

endmodule

// File: tb/tb_rv32i_register_file.sv
// Directed self-checking bench for rv32i_register_file (default and REGFILE_BYPASS_EN builds).
module tb_rv32i_register_file;

    logic        clk;
    logic        rst;
    logic [31:0] reg_write;
    logic        write;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] reg1;
    logic [31:0] reg2;

    int errors = 0;
    int checks = 0;

    rv32i_register_file dut (
        .clk       (clk),
        .rst       (rst),
        .reg_write (reg_write),
        .write     (write),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .reg1      (reg1),
        .reg2      (reg2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // Present a write, let one rising edge take it, then release the write enable.
    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        write     = 1'b1;
        rd        = a;
        reg_write = d;
        @(posedge clk);
        #1;
        write = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic rd_pair(input logic [4:0] a, input logic [4:0] b);
        rs1 = a;
        rs2 = b;
        #1;
    endtask

    function automatic logic [31:0] pat(input int i);
        return (32'h0101_0101 * i) ^ 32'h5A00_00C3;
    endfunction

    initial begin
        rst       = 1'b1;
        write     = 1'b0;
        rd        = 5'd0;
        rs1       = 5'd0;
        rs2       = 5'd0;
        reg_write = 32'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Every index reads zero once a reset edge has occurred.
        for (int i = 0; i < 32; i++) begin
            rd_pair(5'(i), 5'(31 - i));
            chk($sformatf("rst_r1_x%0d", i), reg1, 32'd0);
            chk($sformatf("rst_r2_x%0d", 31 - i), reg2, 32'd0);
        end

        // Reset clears a previously written register.
        do_write(5'd5, 32'hDEAD_BEEF);
        rd_pair(5'd5, 5'd5);
        chk("x5_written", reg1, 32'hDEAD_BEEF);
        do_reset();
        rd_pair(5'd5, 5'd5);
        chk("x5_cleared_r1", reg1, 32'd0);
        chk("x5_cleared_r2", reg2, 32'd0);

        // Basic write/read, checked at the negedge.
        do_write(5'd1, 32'd1);
        rs1 = 5'd1;
        rs2 = 5'd1;
        @(negedge clk);
        chk("basic_r1", reg1, 32'd1);
        chk("basic_r2", reg2, 32'd1);

        // Independent ports.
        do_write(5'd2, 32'hA5A5_A5A5);
        rd_pair(5'd1, 5'd2);
        chk("indep_r1", reg1, 32'd1);
        chk("indep_r2", reg2, 32'hA5A5_A5A5);
        rd_pair(5'd0, 5'd2);
        chk("indep_r1_x0", reg1, 32'd0);
        chk("indep_r2_keep", reg2, 32'hA5A5_A5A5);

        // x0 is immutable.
        do_write(5'd0, 32'hFFFF_FFFF);
        rd_pair(5'd0, 5'd0);
        chk("x0_r1", reg1, 32'd0);
        chk("x0_r2", reg2, 32'd0);

        // Write disabled leaves x3 at its reset value.
        write     = 1'b0;
        rd        = 5'd3;
        reg_write = 32'd7;
        @(posedge clk);
        #1;
        rd_pair(5'd3, 5'd3);
        chk("wr_dis_x3", reg1, 32'd0);

        // Reset beats a simultaneous write and clears older contents.
        do_write(5'd4, 32'h0000_0055);
        rd_pair(5'd4, 5'd1);
        chk("x4_pre", reg1, 32'h0000_0055);
        rst       = 1'b1;
        write     = 1'b1;
        rd        = 5'd4;
        reg_write = 32'd9;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        write = 1'b0;
        rd_pair(5'd4, 5'd1);
        chk("rst_beats_wr_x4", reg1, 32'd0);
        chk("rst_clears_x1", reg2, 32'd0);

        // Same-cycle read of the register being written.
        do_write(5'd6, 32'h0000_1111);
        rs1       = 5'd6;
        rs2       = 5'd6;
        write     = 1'b1;
        rd        = 5'd6;
        reg_write = 32'h0000_1234;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("same_cyc_r1_fwd", reg1, 32'h0000_1234);
        chk("same_cyc_r2_fwd", reg2, 32'h0000_1234);
`else
        chk("same_cyc_r1_old", reg1, 32'h0000_1111);
        chk("same_cyc_r2_old", reg2, 32'h0000_1111);
`endif
        @(posedge clk);
        #1;
        write = 1'b0;
        #1;
        chk("after_edge_r1", reg1, 32'h0000_1234);
        chk("after_edge_r2", reg2, 32'h0000_1234);

`ifdef REGFILE_BYPASS_EN
        // No forwarding while reset is asserted or for rd=0.
        rst       = 1'b1;
        write     = 1'b1;
        rd        = 5'd6;
        reg_write = 32'h0000_BEEF;
        #1;
        chk("no_fwd_in_rst", reg1, 32'h0000_1234);
        rst = 1'b0;
        rd  = 5'd0;
        rs1 = 5'd0;
        #1;
        chk("no_fwd_x0", reg1, 32'd0);
        write = 1'b0;
`endif

        // Fill all registers with distinct values, then read back on both ports.
        for (int i = 1; i < 32; i++) begin
            do_write(5'(i), pat(i));
        end
        for (int i = 0; i < 32; i++) begin
            rd_pair(5'(i), 5'(31 - i));
            chk($sformatf("fill_r1_x%0d", i), reg1, (i == 0) ? 32'd0 : pat(i));
            chk($sformatf("fill_r2_x%0d", 31 - i), reg2, (i == 31) ? 32'd0 : pat(31 - i));
        end

        // Reset in the middle of a write stream: later writes land normally.
        do_write(5'd7, 32'h7777_7777);
        rst       = 1'b1;
        write     = 1'b1;
        rd        = 5'd9;
        reg_write = 32'h9999_9999;
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_write(5'd8, 32'h8888_8888);
        rd_pair(5'd7, 5'd8);
        chk("stream_x7_cleared", reg1, 32'd0);
        chk("stream_x8_landed", reg2, 32'h8888_8888);
        rd_pair(5'd9, 5'd10);
        chk("stream_x9_dropped", reg1, 32'd0);
        chk("stream_x10_cleared", reg2, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rv32i_register_file.md
# rv32i_register_file

Integer register file for the RV32I core: 32 general-purpose registers of 32 bits, two combinational read ports and one clocked write port. It sits between decode (which supplies rs1/rs2/rd) and the execute/writeback stages: read data feeds the ALU operands, and the writeback result returns on the write port. Register x0 is hardwired to zero.

## Interface
- No parameters. Widths are fixed: 32 registers × 32 bits, 5-bit register indices.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous and active-high; clears all registers.
- reg_write  input  32  write data (writeback result).
- write  input  1  write enable.
- rd  input  5  destination register index.
- rs1  input  5  read port 1 register index.
- rs2  input  5  read port 2 register index.
- reg1  output  32  read data for rs1.
- reg2  output  32  read data for rs2.
- One clock; reset is synchronous and active-high.

## Operation
- Storage: x1..x31 are 32-bit flops. x0 has no storage and always reads 0.
- Write: at posedge clk, if rst=0, write=1 and rd≠0, then x[rd] ← reg_write. A write with rd=0 is discarded.
- Reset: at posedge clk with rst=1, x1..x31 ← 0. Reset has priority over a simultaneous write. When rst deasserts, the next edge resumes normal writes.
- Read: reg1 = x[rs1] and reg2 = x[rs2], purely combinational from the array. rs1=0 or rs2=0 yields 0.
- Both ports may address the same register; both return the same value.
- No flags, no handshake. Every write with write=1 and rd≠0 is accepted.

## Timing
- Write latency is one edge: a value written at posedge N appears on reg1/reg2 after posedge N, combinationally, and is stable by the following negedge.
- Read latency is zero cycles: a change in rs1/rs2 changes reg1/reg2 in the same cycle.
- Without bypass, reading rd in the same cycle it is written returns the old value until the edge.
- Output after reset: reg1 and reg2 read 0 for every index once a reset edge has occurred.
- Contents before the first reset edge are undefined. Simulation may show X.
- Reset asserted in the middle of a write stream: the edge with rst=1 clears all registers and drops that write. Writes present while rst=0 still land normally.

## Configuration
- Macro `REGFILE_BYPASS_EN`.
- When defined, write-through forwarding is enabled. If write=1, rd≠0, rst=0 and rd==rs1, then reg1 = reg_write combinationally in the same cycle. The same rule applies to rs2 and reg2. Array update timing is unchanged.
- When undefined, reads come from the array only, as specified under Operation. This is the default.

## Test plan
- Reset clears: write x5=0xDEADBEEF, then assert rst for one edge. With rs1=5 and rs2=5, expect reg1=reg2=0.
- Basic write/read: rst=0, write=1, rd=1, reg_write=1. After the edge, set rs1=1, rs2=1. Expect reg1=1, reg2=1 at the next negedge.
- Independent ports: write x1=1 and x2=0xA5A5A5A5. Set rs1=1, rs2=2. Expect reg1=1, reg2=0xA5A5A5A5. Set rs1=0. Expect reg1=0.
- x0 immutable: write=1, rd=0, reg_write=0xFFFFFFFF. Expect rs1=0 to read 0 after the edge.
- Write disabled: write=0, rd=3, reg_write=7. Expect x3 to keep its prior value (0 after reset).
- Reset beats write: rst=1, write=1, rd=4, reg_write=9 on the same edge. Expect x4=0. With `REGFILE_BYPASS_EN` defined and rst=0, write=1, rd=rs1=6, reg_write=0x1234: expect reg1=0x1234 before the edge.
